// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 dispatcher
package demux_pkg;
  localparam int NCH = 4;
  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = 16;
  typedef logic [1:0] chan_idx_t;
endpackage

// File: rtl/dispatch_slot.sv
// dispatch_slot: single-entry output slot with full flag, data register and transfer counter
module dispatch_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;
  assign w_drain = r_full && i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  // load wins over drain so a same-cycle replace keeps the slot full without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_load) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (w_drain) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux4_dispatch_64.sv
// demux4_dispatch_64: registered 1-to-4 dispatcher with per-channel valid/ready slots
module demux4_dispatch_64
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               S0,
  input  logic               S1,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic [WIDTH-1:0]   O0,
  output logic [WIDTH-1:0]   O1,
  output logic [WIDTH-1:0]   O2,
  output logic [WIDTH-1:0]   O3,
  output logic [NCH*CNT_W-1:0] xfer_cnt
);
  chan_idx_t        w_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_data [NCH];
  assign w_idx = {S1, S0};
  // reset forces ready so upstream sees the dispatcher as empty while it clears
  assign in_ready = rst || !out_valid[w_idx] || out_ready[w_idx];
  assign w_accept = in_valid && in_ready && !rst;
  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_slot
      dispatch_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept && (w_idx == chan_idx_t'(k))),
        .i_data  (in_data),
        .i_ready (out_ready[k]),
        .o_valid (out_valid[k]),
        .o_data  (w_data[k]),
        .o_cnt   (xfer_cnt[k*CNT_W +: CNT_W])
      );
    end
  endgenerate
  assign O0 = w_data[0];
  assign O1 = w_data[1];
  assign O2 = w_data[2];
  assign O3 = w_data[3];
endmodule
